// File: rtl/mem_port_arbiter_if.sv
// Bundle of every non-clock/reset signal of the shared memory port arbiter.
//  slave  : the arbiter's view. It takes the fetch/data requests and the memory response,
//           and it drives the results, the stalls and the memory request.
//  master : the environment's view (pipeline + memory), with the directions reversed.
// Parameters: AW address width, DW data/instruction width.
interface mem_port_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_flush;
    logic [DW-1:0] if_instr;
    logic          if_valid;
    logic          if_stall;
    logic          d_rd_en;
    logic          d_wr_en;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_valid;
    logic          d_stall;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    modport slave (
        input  if_req, if_addr, if_flush, d_rd_en, d_wr_en, d_addr, d_wdata, mem_rdata, mem_ack,
        output if_instr, if_valid, if_stall, d_rdata, d_valid, d_stall,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, if_flush, d_rd_en, d_wr_en, d_addr, d_wdata, mem_rdata, mem_ack,
        input  if_instr, if_valid, if_stall, d_rdata, d_valid, d_stall,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one unified memory port between instruction fetch (IF) and the
// data stage (D). Each access is sequenced over a variable-latency req/ack memory, and its
// result is returned as a one-cycle valid pulse. Fetches cancelled by a taken branch are
// dropped. A starvation counter forces an IF grant after STARVE_MAX D grants that were made
// while IF was waiting.
// Ports:
//  clk, rst_n : clock, asynchronous active-low reset
//  bus        : mem_port_arbiter_if.slave
//               - fetch side if_*
//               - data side d_*
//               - memory side mem_*
// All outputs are registered except if_stall and d_stall, which are combinational.
module mem_port_arbiter #(
    parameter int            AW         = 16,
    parameter int            DW         = 16,
    parameter logic [DW-1:0] NOP_INSTR  = 16'h0000,
    parameter int            STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_port_arbiter_if.slave     bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        D_BUSY  = 2'd2,
        IF_DROP = 2'd3
    } state_t;

    state_t        state_r;
    logic [SW-1:0] starve_cnt_r;
    logic [SW-1:0] starve_nxt_s;
    logic          mem_en_r;
    logic          mem_we_r;
    logic [AW-1:0] mem_addr_r;
    logic [DW-1:0] mem_wdata_r;
    logic          if_valid_r;
    logic [DW-1:0] if_instr_r;
    logic          d_valid_r;
    logic [DW-1:0] d_rdata_r;
    logic          if_elig_s;
    logic          d_elig_s;
    logic          grant_if_s;
    logic          grant_d_s;

    assign bus.mem_en    = mem_en_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.if_valid  = if_valid_r;
    assign bus.if_instr  = if_instr_r;
    assign bus.d_valid   = d_valid_r;
    assign bus.d_rdata   = d_rdata_r;
    assign bus.if_stall  = bus.if_req & ~if_valid_r;
    assign bus.d_stall   = (bus.d_rd_en | bus.d_wr_en) & ~d_valid_r;

    // IDLE arbitration.
    // A requester whose completion pulse is high this cycle is skipped, so a finished
    // access is not issued a second time.
    always_comb begin
        if_elig_s = bus.if_req & ~bus.if_flush & ~if_valid_r;
        d_elig_s  = (bus.d_rd_en | bus.d_wr_en) & ~d_valid_r;
        if (if_elig_s && (!d_elig_s || (starve_cnt_r == SW'(STARVE_MAX)))) begin
            grant_if_s = 1'b1;
            grant_d_s  = 1'b0;
        end else begin
            grant_if_s = 1'b0;
            grant_d_s  = d_elig_s;
        end
    end

    // Starvation counter next value.
    // It counts D grants taken while IF was waiting, and clears on an IF grant or when
    // if_req is idle.
    always_comb begin
        if (!bus.if_req) begin
            starve_nxt_s = {SW{1'b0}};
        end else if ((state_r == IDLE) && grant_if_s) begin
            starve_nxt_s = {SW{1'b0}};
        end else if ((state_r == IDLE) && grant_d_s && !bus.if_flush) begin
            if (starve_cnt_r == SW'(STARVE_MAX)) begin
                starve_nxt_s = starve_cnt_r;
            end else begin
                starve_nxt_s = starve_cnt_r + SW'(1);
            end
        end else begin
            starve_nxt_s = starve_cnt_r;
        end
    end

    // Access sequencer FSM with registered memory-side and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            starve_cnt_r <= {SW{1'b0}};
            mem_en_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= {AW{1'b0}};
            mem_wdata_r  <= {DW{1'b0}};
            if_valid_r   <= 1'b0;
            if_instr_r   <= NOP_INSTR;
            d_valid_r    <= 1'b0;
            d_rdata_r    <= {DW{1'b0}};
        end else begin
            // Valid pulses last one cycle. if_instr returns to NOP unless it is being loaded.
            if_valid_r   <= 1'b0;
            d_valid_r    <= 1'b0;
            if_instr_r   <= NOP_INSTR;
            starve_cnt_r <= starve_nxt_s;
            case (state_r)
                IDLE: begin
                    if (grant_if_s) begin
                        state_r    <= IF_BUSY;
                        mem_en_r   <= 1'b1;
                        mem_we_r   <= 1'b0;
                        mem_addr_r <= bus.if_addr;
                    end else if (grant_d_s) begin
                        state_r    <= D_BUSY;
                        mem_en_r   <= 1'b1;
                        mem_we_r   <= bus.d_wr_en;
                        mem_addr_r <= bus.d_addr;
                        if (bus.d_wr_en) begin
                            mem_wdata_r <= bus.d_wdata;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                IF_BUSY: begin
                    if (bus.mem_ack) begin
                        state_r  <= IDLE;
                        mem_en_r <= 1'b0;
                        mem_we_r <= 1'b0;
                        // A flush arriving together with the ack discards the fetched word.
                        if (!bus.if_flush) begin
                            if_valid_r <= 1'b1;
                            if_instr_r <= bus.mem_rdata;
                        end
                    end else if (bus.if_flush) begin
                        // The memory cycle cannot be withdrawn. Let it finish, then discard it.
                        state_r <= IF_DROP;
                    end else begin
                        state_r <= IF_BUSY;
                    end
                end
                D_BUSY: begin
                    if (bus.mem_ack) begin
                        state_r   <= IDLE;
                        mem_en_r  <= 1'b0;
                        mem_we_r  <= 1'b0;
                        d_valid_r <= 1'b1;
                        if (!mem_we_r) begin
                            d_rdata_r <= bus.mem_rdata;
                        end
                    end else begin
                        state_r <= D_BUSY;
                    end
                end
                IF_DROP: begin
                    if (bus.mem_ack) begin
                        state_r  <= IDLE;
                        mem_en_r <= 1'b0;
                        mem_we_r <= 1'b0;
                    end else begin
                        state_r <= IF_DROP;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    mem_en_r <= 1'b0;
                    mem_we_r <= 1'b0;
                end
            endcase
        end
    end
endmodule
